// File: rtl/noc_pkg.sv
// Shared NOC definitions: packet field layout, packet struct, injector
// state type, LFSR polynomial and small helpers used by traffic sources.
package noc_pkg;

  localparam int DST_HI = 56;
  localparam int DST_LO = 53;
  localparam int SRC_HI = 52;
  localparam int SRC_LO = 49;
  localparam int SEQ_HI = 48;
  localparam int SEQ_LO = 33;
  localparam int PAY_HI = 32;
  localparam int PAY_LO = 0;
  localparam int PKT_W  = DST_HI + 1;

  localparam logic [31:0] LFSR_POLY = 32'h80200003;

  typedef struct packed {
    logic [DST_HI-DST_LO:0] dst;
    logic [SRC_HI-SRC_LO:0] src;
    logic [SEQ_HI-SEQ_LO:0] seq;
    logic [PAY_HI-PAY_LO:0] pay;
  } noc_pkt_t;

  typedef enum logic [1:0] {IDLE, GAP, SEND, DONE} inj_state_t;

  // Right-shifting Galois step: the bit shifted out selects the tap mask.
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return {1'b0, v[31:1]} ^ (v[0] ? LFSR_POLY : '0);
  endfunction

  // Destination from the low LFSR bits; a node never addresses itself.
  function automatic logic [3:0] pick_dst(input logic [3:0] low,
                                          input logic [3:0] node,
                                          input logic [3:0] mask);
    logic [3:0] d;
    d = low & mask;
    if (d == node) d = (node + 4'd1) & mask;
    return d;
  endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit Galois LFSR, advanced one step per cycle with adv high.
// Ports: clk, rst_n (async active-low, loads seed; zero seed becomes 1),
//        seed (reset value), adv (advance enable), value (current state).
module lfsr32
  import noc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] seed,
  input  logic        adv,
  output logic [31:0] value
);

  logic [31:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (adv) value_d = lfsr_step(value_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value_q <= (seed == '0) ? 32'h1 : seed;
    else        value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/packet_injector.sv
// Traffic source for one mesh NOC node: builds {dst, src, seq, payload}
// packets and drives them into the router injection port (valid/ready).
// Ports: clk, rst_n (async active-low), start (run trigger, IDLE/DONE only),
//        out_valid/out_ready/out_data (injection handshake), done (run
//        complete), sent_cnt (accepted packets this run), stall_cnt
//        (valid-but-not-ready cycles, saturating).
module packet_injector
  import noc_pkg::*;
#(
  parameter int          NODE      = 0,
  parameter int          WIDTH     = 57,
  parameter int          NUM_NODES = 16,
  parameter int          NUM_PKTS  = 8,
  parameter int          GAP       = 2,
  parameter logic [31:0] SEED      = 32'h1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             done,
  output logic [15:0]      sent_cnt,
  output logic [15:0]      stall_cnt
);

  localparam logic [31:0] SEED_EFF = (SEED == '0) ? 32'h1 : SEED;
  localparam logic [3:0]  NODE_ID  = 4'(NODE);
  localparam logic [3:0]  DST_MASK = 4'(NUM_NODES - 1);
  localparam logic [15:0] PKTS_W   = 16'(NUM_PKTS);
  localparam logic [15:0] GAP_W    = 16'(GAP);

  inj_state_t       state_q, state_d;
  logic [15:0]      gap_cnt_q, gap_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             done_q, done_d;
  logic [15:0]      sent_cnt_q, sent_cnt_d;
  logic [15:0]      stall_cnt_q, stall_cnt_d;
  logic [15:0]      seq_q, seq_d;

  logic [31:0] lfsr_val;
  logic        xfer;

  assign xfer = out_valid_q && out_ready;

  lfsr32 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (SEED_EFF),
    .adv   (xfer),
    .value (lfsr_val)
  );

  function automatic logic [WIDTH-1:0] form_pkt(input logic [15:0] seq,
                                                input logic [31:0] lfsr);
    noc_pkt_t p;
    p.dst = pick_dst(lfsr[3:0], NODE_ID, DST_MASK);
    p.src = NODE_ID;
    p.seq = seq;
    p.pay = {1'b0, lfsr};
    return WIDTH'(p);
  endfunction

  // The parameter GAP shadows the imported state name, so that state is
  // referenced through the package scope.
  always_comb begin
    state_d     = state_q;
    gap_cnt_d   = gap_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    done_d      = done_q;
    sent_cnt_d  = sent_cnt_q;
    stall_cnt_d = stall_cnt_q;
    seq_d       = seq_q;

    if (out_valid_q && !out_ready && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 16'd1;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          done_d      = 1'b0;
          sent_cnt_d  = '0;
          stall_cnt_d = '0;
          seq_d       = '0;
          if (GAP == 0) begin
            state_d     = SEND;
            out_valid_d = 1'b1;
            out_data_d  = form_pkt('0, lfsr_val);
          end else begin
            state_d   = noc_pkg::GAP;
            gap_cnt_d = GAP_W;
          end
        end
      end
      noc_pkg::GAP: begin
        gap_cnt_d = gap_cnt_q - 16'd1;
        if (gap_cnt_d == '0) begin
          state_d     = SEND;
          out_valid_d = 1'b1;
          out_data_d  = form_pkt(seq_q, lfsr_val);
        end
      end
      SEND: begin
        if (xfer) begin
          sent_cnt_d = sent_cnt_q + 16'd1;
          seq_d      = seq_q + 16'd1;
          if (NUM_PKTS != 0 && sent_cnt_d == PKTS_W) begin
            state_d     = DONE;
            done_d      = 1'b1;
            out_valid_d = 1'b0;
          end else if (GAP == 0) begin
            // Back-to-back: the LFSR register advances on this same edge,
            // so the next packet uses its stepped value directly.
            out_data_d = form_pkt(seq_d, lfsr_step(lfsr_val));
          end else begin
            state_d     = noc_pkg::GAP;
            gap_cnt_d   = GAP_W;
            out_valid_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gap_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
      sent_cnt_q  <= '0;
      stall_cnt_q <= '0;
      seq_q       <= '0;
    end else begin
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
      sent_cnt_q  <= sent_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      seq_q       <= seq_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign done      = done_q;
  assign sent_cnt  = sent_cnt_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_packet_injector.sv
module tb_packet_injector;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // a: NODE 5, 3 pkts, GAP 2    b: NODE 0, 4 pkts, GAP 0
  // c: NODE 3, 12 pkts, GAP 1, SEED 3 (self-address), random ready
  // d: NODE 6 of 8, continuous, GAP 0, SEED 0
  logic start_a, ready_a, valid_a, done_a;
  logic start_b, ready_b, valid_b, done_b;
  logic start_c, ready_c, valid_c, done_c;
  logic start_d, ready_d, valid_d, done_d;
  logic [56:0] data_a, data_b, data_c, data_d;
  logic [15:0] sent_a, sent_b, sent_c, sent_d;
  logic [15:0] stall_a, stall_b, stall_c, stall_d;

  packet_injector #(.NODE(5), .WIDTH(57), .NUM_NODES(16), .NUM_PKTS(3), .GAP(2), .SEED(32'h1))
    dut_a (.clk(clk), .rst_n(rst_n), .start(start_a), .out_valid(valid_a), .out_ready(ready_a),
           .out_data(data_a), .done(done_a), .sent_cnt(sent_a), .stall_cnt(stall_a));
  packet_injector #(.NODE(0), .WIDTH(57), .NUM_NODES(16), .NUM_PKTS(4), .GAP(0), .SEED(32'hACE1))
    dut_b (.clk(clk), .rst_n(rst_n), .start(start_b), .out_valid(valid_b), .out_ready(ready_b),
           .out_data(data_b), .done(done_b), .sent_cnt(sent_b), .stall_cnt(stall_b));
  packet_injector #(.NODE(3), .WIDTH(57), .NUM_NODES(16), .NUM_PKTS(12), .GAP(1), .SEED(32'h3))
    dut_c (.clk(clk), .rst_n(rst_n), .start(start_c), .out_valid(valid_c), .out_ready(ready_c),
           .out_data(data_c), .done(done_c), .sent_cnt(sent_c), .stall_cnt(stall_c));
  packet_injector #(.NODE(6), .WIDTH(57), .NUM_NODES(8), .NUM_PKTS(0), .GAP(0), .SEED(32'h0))
    dut_d (.clk(clk), .rst_n(rst_n), .start(start_d), .out_valid(valid_d), .out_ready(ready_d),
           .out_data(data_d), .done(done_d), .sent_cnt(sent_d), .stall_cnt(stall_d));

  // Reference LFSR: shift right by one; if the bit shifted out was 1,
  // xor in the polynomial.
  function automatic logic [31:0] madv(input logic [31:0] v);
    return (v >> 1) ^ (((v % 2) == 1) ? 32'h80200003 : 32'h0);
  endfunction

  function automatic logic [56:0] mpkt(input int unsigned node, input int unsigned nn,
                                       input int unsigned seq, input logic [31:0] v);
    int unsigned d;
    d = v % nn;
    if (d == node) d = (node + 1) % nn;
    return {4'(d), 4'(node), 16'(seq), 1'b0, v};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] v;
    logic [56:0] first;
    logic [56:0] prev;
    int k;
    int w;
    int stall_exp;
    bit held;
    bit dst_checked;

    start_a = 0; start_b = 0; start_c = 0; start_d = 0;
    ready_a = 1; ready_b = 1; ready_c = 0; ready_d = 1;

    // Reset state
    repeat (3) tick();
    chk("rst_valid", 64'(valid_a), 64'(0));
    chk("rst_data", 64'(data_a), 64'(0));
    chk("rst_done", 64'(done_a), 64'(0));
    chk("rst_sent", 64'(sent_a), 64'(0));
    chk("rst_stall", 64'(stall_a), 64'(0));
    rst_n = 1;
    tick(); tick();

    // A: GAP=2, 3 packets, ready tied high
    v = 32'h1;
    k = 0;
    start_a = 1; tick(); start_a = 0;
    for (int i = 1; i <= 12; i++) begin
      bit exp_v;
      exp_v = (i >= 3) && (i <= 9) && ((i - 3) % 3 == 0);
      chk("a_valid", 64'(valid_a), 64'(exp_v));
      chk("a_done", 64'(done_a), 64'(i >= 10));
      if (exp_v && valid_a) begin
        chk("a_pkt", 64'(data_a), 64'(mpkt(5, 16, k, v)));
        chk("a_src", 64'(data_a[52:49]), 64'(5));
        v = madv(v);
        k++;
      end
      tick();
    end
    chk("a_sent", 64'(sent_a), 64'(3));
    chk("a_stall0", 64'(stall_a), 64'(0));

    // A run 2: stall first packet for 7 cycles; LFSR continues, not reseeded
    ready_a = 0;
    start_a = 1; tick(); start_a = 0;
    w = 0;
    while (!valid_a && w < 10) begin tick(); w++; end
    chk("a_stall_wait", 64'(valid_a), 64'(1));
    first = data_a;
    chk("a_r2_pkt0", 64'(data_a), 64'(mpkt(5, 16, 0, v)));
    for (int j = 0; j < 7; j++) begin
      chk("a_hold_valid", 64'(valid_a), 64'(1));
      chk("a_hold_data", 64'(data_a), 64'(first));
      tick();
    end
    chk("a_stall7", 64'(stall_a), 64'(7));
    chk("a_hold_data_end", 64'(data_a), 64'(first));
    ready_a = 1;
    tick();
    v = madv(v);
    w = 0;
    while (!valid_a && w < 10) begin tick(); w++; end
    chk("a_r2_pkt1", 64'(data_a), 64'(mpkt(5, 16, 1, v)));
    w = 0;
    while (!done_a && w < 20) begin tick(); w++; end
    chk("a_r2_done", 64'(done_a), 64'(1));
    chk("a_r2_sent", 64'(sent_a), 64'(3));
    chk("a_r2_stall", 64'(stall_a), 64'(7));

    // B: GAP=0 back-to-back, 4 packets
    v = 32'hACE1;
    start_b = 1; tick(); start_b = 0;
    for (int i = 0; i < 4; i++) begin
      chk("b_valid", 64'(valid_b), 64'(1));
      chk("b_pkt", 64'(data_b), 64'(mpkt(0, 16, i, v)));
      v = madv(v);
      tick();
    end
    chk("b_valid_end", 64'(valid_b), 64'(0));
    chk("b_done", 64'(done_b), 64'(1));
    chk("b_sent", 64'(sent_b), 64'(4));

    // Reset mid-SEND on B
    start_b = 1; tick(); start_b = 0;
    tick();
    chk("b_pre_rst_valid", 64'(valid_b), 64'(1));
    chk("b_pre_rst_sent", 64'(sent_b), 64'(1));
    #2 rst_n = 0;
    #1;
    chk("b_rst_valid", 64'(valid_b), 64'(0));
    chk("b_rst_data", 64'(data_b), 64'(0));
    chk("b_rst_sent", 64'(sent_b), 64'(0));
    chk("b_rst_stall", 64'(stall_b), 64'(0));
    chk("b_rst_done", 64'(done_b), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    tick();
    start_b = 1; tick(); start_b = 0;
    chk("b_restart_valid", 64'(valid_b), 64'(1));
    chk("b_restart_pkt", 64'(data_b), 64'(mpkt(0, 16, 0, 32'hACE1)));
    repeat (5) tick();
    chk("b_restart_done", 64'(done_b), 64'(1));

    // C: self-address and random back-pressure
    v = 32'h3;
    k = 0;
    stall_exp = 0;
    held = 0;
    dst_checked = 0;
    prev = '0;
    start_c = 1; tick(); start_c = 0;
    w = 0;
    while (k < 12 && w < 400) begin
      ready_c = ($urandom_range(0, 3) != 0);
      if (held) begin
        chk("c_hold_valid", 64'(valid_c), 64'(1));
        chk("c_hold_data", 64'(data_c), 64'(prev));
      end
      held = 0;
      if (valid_c) begin
        if (!dst_checked) begin
          chk("c_self_dst", 64'(data_c[56:53]), 64'(4));
          dst_checked = 1;
        end
        if (ready_c) begin
          chk("c_pkt", 64'(data_c), 64'(mpkt(3, 16, k, v)));
          v = madv(v);
          k++;
        end else begin
          stall_exp++;
          held = 1;
          prev = data_c;
        end
      end
      tick();
      w++;
    end
    chk("c_count", 64'(k), 64'(12));
    chk("c_done", 64'(done_c), 64'(1));
    chk("c_sent", 64'(sent_c), 64'(12));
    chk("c_stall", 64'(stall_c), 64'(stall_exp));

    // D: continuous, seq wraps, done never, stray starts ignored
    v = 32'h1;
    start_d = 1; tick(); start_d = 0;
    for (int i = 0; i < 70000; i++) begin
      start_d = (i % 9000 == 4500);
      chk("d_run", 64'({valid_d, done_d, data_d}), 64'({1'b1, 1'b0, mpkt(6, 8, i % 65536, v)}));
      if (i == 65536) begin
        chk("d_seq_wrap", 64'(data_d[48:33]), 64'(0));
        chk("d_sent_wrap", 64'(sent_d), 64'(0));
      end
      v = madv(v);
      tick();
    end
    start_d = 0;
    chk("d_sent_end", 64'(sent_d), 64'(70000 % 65536));
    chk("d_stall_end", 64'(stall_d), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/packet_injector.md
Name: packet_injector

Overview:
- Synchronous traffic source for one mesh NOC node; the transmit-side counterpart of the per-node output sink.
- Builds WIDTH-bit packets (destination, source, sequence number, pseudo-random payload) and drives them into the node's router injection port over a valid/ready handshake.
- Packet count and inter-packet gap are parameterised; a start/done pair lets the testbench sequence traffic phases.

Parameters:
- NODE, 0: this node's ID; placed in the src field.
- WIDTH, 57: packet width.
- NUM_NODES, 16: mesh node count; power of 2, at most 16.
- NUM_PKTS, 8: packets per run; 0 = run continuously.
- GAP, 2: idle cycles inserted before every packet, including the first.
- SEED, 32'h1: LFSR seed; a value of 0 is replaced by 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle pulse; sampled only in IDLE or DONE.
- out_valid  out  1  packet on out_data is valid.
- out_ready  in  1  router accepts the packet.
- out_data  out  WIDTH  packet.
- done  out  1  run complete.
- sent_cnt  out  16  packets accepted in the current run.
- stall_cnt  out  16  cycles with out_valid=1 and out_ready=0; saturates at 16'hFFFF.

Behaviour:
- All outputs are registered.
- Reset (async assert, sync deassert) forces:
  - state=IDLE; out_valid=0; out_data=0; done=0; sent_cnt=0; stall_cnt=0; seq=0; lfsr=SEED (or 1 if SEED=0).
  - Reset asserted mid-packet drops the packet immediately; it is never resumed.
- Packet format:
  - [56:53] dst; [52:49] src=NODE; [48:33] seq (16-bit, wraps FFFF->0); [32:0] {1'b0, lfsr}.
- Destination:
  - dst = lfsr[log2(NUM_NODES)-1:0].
  - If dst==NODE, dst=(NODE+1) mod NUM_NODES, so a node never addresses itself.
  - Upper dst bits are 0.
- LFSR:
  - 32-bit Galois, polynomial 0x80200003.
  - Advances exactly once per accepted packet, never otherwise.
- Handshake:
  - Transfer occurs on a rising edge where out_valid && out_ready.
  - While out_valid=1 and no transfer, out_data is held stable and out_valid stays high.
  - out_ready is ignored when out_valid=0.
- FSM:
  - IDLE: start -> GAP with gap_cnt=GAP, or straight to SEND if GAP=0. On entering a run: sent_cnt=0, stall_cnt=0, seq=0.
  - GAP: gap_cnt decrements each cycle; at 0 -> SEND. out_valid=0.
  - SEND: out_valid=1, out_data formed on entry. On transfer:
    - sent_cnt++, seq++, lfsr advances.
    - If NUM_PKTS!=0 and the new sent_cnt equals NUM_PKTS -> DONE.
    - Else if GAP=0, stay in SEND; the next packet is presented in the following cycle with out_valid kept high (back-to-back, 1 packet/cycle).
    - Else -> GAP.
  - DONE: done=1, out_valid=0. start -> re-enter the run as from IDLE (done cleared the same edge). The LFSR is NOT reseeded.
- Latency: start pulse to first out_valid = GAP+1 cycles.
- stall_cnt increments in any cycle where out_valid && !out_ready; it holds at FFFF.
- sent_cnt wraps at 16 bits in continuous mode.
- A start pulse in GAP or SEND is ignored.

Decomposition:
- Shared package noc_pkg holds:
  - field offsets/widths (DST_HI/LO, SRC_HI/LO, SEQ_HI/LO, PAY_HI/LO);
  - packed struct noc_pkt_t;
  - enum inj_state_t {IDLE, GAP, SEND, DONE};
  - constant LFSR_POLY = 32'h80200003.
- Sub-module lfsr32 (inputs clk, rst_n, seed, adv; output value) is instantiated once; the same sub-module is reused by other traffic generators.

Test Plan:
- NODE=5, NUM_PKTS=3, GAP=2, out_ready tied 1, start at cycle 10:
  - out_valid rises at cycle 13;
  - three single-cycle transfers spaced by 2 idle cycles;
  - seq 0,1,2; src=5 in every packet;
  - done=1 after the third transfer; sent_cnt=3; stall_cnt=0.
- GAP=0, NUM_PKTS=4, ready=1: four consecutive valid cycles with seq 0..3, then done.
- Hold out_ready=0 for 7 cycles during the first packet:
  - out_data stable for all 7 cycles;
  - stall_cnt=7 at the end;
  - the LFSR has not advanced (next payload equals a reference model value computed after one advance).
- Self-address: NODE=3, SEED chosen so that lfsr[3:0]=3 -> emitted dst=4.
- Assert rst_n low mid-SEND and hold 2 cycles:
  - out_valid=0 asynchronously;
  - all counters 0;
  - a start after release begins again at seq 0.
- NUM_PKTS=0, ready=1, GAP=0 for 70000 cycles:
  - seq wraps from FFFF to 0;
  - done never asserts;
  - start pulses during the run are ignored.
